// File: rtl/memory_pkg.sv
// Shared types and default widths for the memory responder and its RAM.
package memory_pkg;

  localparam int DEFAULT_DATA_W = 16;
  localparam int DEFAULT_ADDR_W = 8;
  localparam int CNT_W          = 4;

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;
  typedef enum logic [1:0] {NONE, IPORT, DPORT} grant_t;

endpackage

// File: rtl/memory_array.sv
// Single-port synchronous RAM: write-enable, registered read, contents never reset.
module memory_array
  import memory_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  // Read-first: a write and a read of the same word in one edge return the old word.
  always_ff @(posedge clock) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/memory_responder.sv
// Two-port (fetch / load-store) responder over one RAM, D port priority, programmable wait states.
// Optional store protection below PROTECT_LIMIT: define MEMORY_RESPONDER_WRITE_PROTECT_EN.
module memory_responder
  import memory_pkg::*;
#(
  parameter int DATA_W        = DEFAULT_DATA_W,
  parameter int ADDR_W        = DEFAULT_ADDR_W,
  parameter int WAIT_CYCLES   = 1,
  parameter int PROTECT_LIMIT = 'h40
) (
  input  logic              clock,
  input  logic              resetN,
  input  logic              iReq,
  input  logic [ADDR_W-1:0] iAddr,
  output logic              iAck,
  output logic [DATA_W-1:0] iRdata,
  input  logic              dReq,
  input  logic              dWe,
  input  logic [ADDR_W-1:0] dAddr,
  input  logic [DATA_W-1:0] dWdata,
  output logic              dAck,
  output logic [DATA_W-1:0] dRdata,
  output logic              busy,
  output logic              dErr
);

  localparam logic [CNT_W-1:0]  WAIT_INIT = CNT_W'(WAIT_CYCLES);
  localparam logic [ADDR_W-1:0] LIMIT     = ADDR_W'(PROTECT_LIMIT);

  state_t            state_reg, state_next;
  grant_t            grant_reg, grant_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic              we_reg, we_next;
  logic [DATA_W-1:0] wdata_reg, wdata_next;
  logic [DATA_W-1:0] i_rdata_reg, i_rdata_next;
  logic [DATA_W-1:0] d_rdata_reg, d_rdata_next;
  logic [DATA_W-1:0] ram_rdata;
  logic              ram_we;
  logic              req_held;
  logic              take_d, take_i;
  logic              below_limit;
  logic              blocked;

  assign below_limit = (addr_reg < LIMIT);

`ifdef MEMORY_RESPONDER_WRITE_PROTECT_EN
  assign blocked = below_limit;
`else
  logic unused_limit;
  assign unused_limit = below_limit;
  assign blocked      = 1'b0;
`endif

  assign req_held = (grant_reg == IPORT) ? iReq :
                    (grant_reg == DPORT) ? dReq : 1'b0;

  always_comb begin
    state_next   = state_reg;
    grant_next   = grant_reg;
    cnt_next     = cnt_reg;
    addr_next    = addr_reg;
    we_next      = we_reg;
    wdata_next   = wdata_reg;
    i_rdata_next = i_rdata_reg;
    d_rdata_next = d_rdata_reg;
    ram_we       = 1'b0;
    take_d       = 1'b0;
    take_i       = 1'b0;

    case (state_reg)
      IDLE: begin
        take_d = dReq;
        take_i = !dReq && iReq;
      end
      WAIT: begin
        if (!req_held) begin
          state_next = IDLE;
          grant_next = NONE;
        end else if (cnt_reg == '0) begin
          state_next = ACK;
          ram_we     = (grant_reg == DPORT) && we_reg && !blocked;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      ACK: begin
        state_next = IDLE;
        grant_next = NONE;
        if (grant_reg == IPORT) i_rdata_next = ram_rdata;
        if (grant_reg == DPORT && !we_reg) d_rdata_next = ram_rdata;
        // The just-served port's req is ambiguous here, but the other port's pending
        // req is genuine and can be granted now to keep alternating traffic at W+2.
        take_d = (grant_reg == IPORT) && dReq;
        take_i = (grant_reg == DPORT) && iReq;
      end
      default: begin
        state_next = IDLE;
        grant_next = NONE;
      end
    endcase

    if (take_d) begin
      state_next = WAIT;
      grant_next = DPORT;
      cnt_next   = WAIT_INIT;
      addr_next  = dAddr;
      we_next    = dWe;
      wdata_next = dWdata;
    end else if (take_i) begin
      state_next = WAIT;
      grant_next = IPORT;
      cnt_next   = WAIT_INIT;
      addr_next  = iAddr;
      we_next    = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_reg   <= IDLE;
      grant_reg   <= NONE;
      cnt_reg     <= '0;
      addr_reg    <= '0;
      we_reg      <= 1'b0;
      wdata_reg   <= '0;
      i_rdata_reg <= '0;
      d_rdata_reg <= '0;
    end else begin
      state_reg   <= state_next;
      grant_reg   <= grant_next;
      cnt_reg     <= cnt_next;
      addr_reg    <= addr_next;
      we_reg      <= we_next;
      wdata_reg   <= wdata_next;
      i_rdata_reg <= i_rdata_next;
      d_rdata_reg <= d_rdata_next;
    end
  end

  memory_array #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_array (
    .clock (clock),
    .we    (ram_we),
    .addr  (addr_reg),
    .wdata (wdata_reg),
    .rdata (ram_rdata)
  );

  assign busy = (state_reg != IDLE);
  assign iAck = (state_reg == ACK) && (grant_reg == IPORT);
  assign dAck = (state_reg == ACK) && (grant_reg == DPORT);

  // In the ack cycle the RAM output register already holds the word; it is captured at the ack edge.
  assign iRdata = iAck ? ram_rdata : i_rdata_reg;
  assign dRdata = (dAck && !we_reg) ? ram_rdata : d_rdata_reg;

`ifdef MEMORY_RESPONDER_WRITE_PROTECT_EN
  assign dErr = dAck && we_reg && blocked;
`else
  assign dErr = 1'b0;
`endif

endmodule

// File: tb/tb_memory_responder.sv
// Directed bench for memory_responder with a cycle-schedule model and literal spot checks.
module tb_memory_responder;

  localparam int W = 1;
  localparam int N = 2048;

  logic        clock = 1'b0;
  logic        resetN = 1'b0;
  logic        iReq = 1'b0, dReq = 1'b0, dWe = 1'b0;
  logic [7:0]  iAddr = '0, dAddr = '0;
  logic [15:0] dWdata = '0;
  logic        iAck, dAck, busy, dErr;
  logic [15:0] iRdata, dRdata;

  memory_responder #(.DATA_W(16), .ADDR_W(8), .WAIT_CYCLES(W), .PROTECT_LIMIT('h40)) dut (
    .clock(clock), .resetN(resetN),
    .iReq(iReq), .iAddr(iAddr), .iAck(iAck), .iRdata(iRdata),
    .dReq(dReq), .dWe(dWe), .dAddr(dAddr), .dWdata(dWdata),
    .dAck(dAck), .dRdata(dRdata), .busy(busy), .dErr(dErr)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int busy_total = 0;

  // Model: word memory plus a per-cycle schedule of expected outputs.
  logic [15:0] mem_model [256];
  bit          mem_known [256];
  bit          busy_exp [N], iack_exp [N], dack_exp [N], derr_exp [N], dload_exp [N];
  bit          iknown_exp [N], dknown_exp [N];
  logic [15:0] idata_exp [N], ddata_exp [N];
  logic [15:0] exp_i_rdata = '0, exp_d_rdata = '0;
  bit          exp_i_valid = 1'b1, exp_d_valid = 1'b1;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  function automatic bit is_blocked(input bit we, input logic [7:0] a);
`ifdef MEMORY_RESPONDER_WRITE_PROTECT_EN
    return we && (a < 8'h40);
`else
    return 1'b0;
`endif
  endfunction

  always @(negedge clock) begin
    if (!resetN) begin
      check("rst_iAck", iAck, 0);
      check("rst_dAck", dAck, 0);
      check("rst_busy", busy, 0);
      check("rst_dErr", dErr, 0);
      check("rst_iRdata", iRdata, 16'h0000);
      check("rst_dRdata", dRdata, 16'h0000);
    end else begin
      if (iack_exp[cyc]) begin
        exp_i_rdata = idata_exp[cyc];
        exp_i_valid = iknown_exp[cyc];
      end
      if (dack_exp[cyc] && dload_exp[cyc]) begin
        exp_d_rdata = ddata_exp[cyc];
        exp_d_valid = dknown_exp[cyc];
      end
      if (busy) busy_total++;
      check("iAck", iAck, iack_exp[cyc]);
      check("dAck", dAck, dack_exp[cyc]);
      check("busy", busy, busy_exp[cyc]);
      check("dErr", dErr, derr_exp[cyc]);
      if (exp_i_valid) check("iRdata", iRdata, exp_i_rdata);
      if (exp_d_valid) check("dRdata", dRdata, exp_d_rdata);
    end
  end

  task automatic access(input bit port_d, input bit we, input logic [7:0] a, input logic [15:0] wd);
    int k, ack;
    bit blk;
    @(negedge clock);
    if (port_d) begin
      dReq = 1'b1; dWe = we; dAddr = a; dWdata = wd;
    end else begin
      iReq = 1'b1; iAddr = a;
    end
    k   = cyc + 1;
    ack = k + 1 + W;
    blk = port_d && is_blocked(we, a);
    for (int c = k; c <= ack; c++) busy_exp[c] = 1'b1;
    if (port_d) begin
      dack_exp[ack] = 1'b1;
      derr_exp[ack] = blk;
      if (!we) begin
        dload_exp[ack]  = 1'b1;
        ddata_exp[ack]  = mem_model[a];
        dknown_exp[ack] = mem_known[a];
      end
    end else begin
      iack_exp[ack]   = 1'b1;
      idata_exp[ack]  = mem_model[a];
      iknown_exp[ack] = mem_known[a];
    end
    while (cyc < ack) @(negedge clock);
    if (port_d) dReq = 1'b0; else iReq = 1'b0;
    if (port_d && we && !blk) begin
      mem_model[a] = wd;
      mem_known[a] = 1'b1;
    end
    $display("txn %s %s addr=%h wdata=%h ack_cyc=%0d blocked=%0d", port_d ? "D" : "I",
             we ? "store" : "load ", a, wd, ack, blk);
    @(negedge clock);
  endtask

  task automatic reset_idle();
    @(negedge clock);
    resetN = 1'b0;
    exp_i_rdata = '0; exp_d_rdata = '0; exp_i_valid = 1'b1; exp_d_valid = 1'b1;
    @(negedge clock);
    resetN = 1'b1;
    $display("txn reset (idle) cyc=%0d", cyc);
  endtask

  task automatic simultaneous();
    int k, da, ia;
    @(negedge clock);
    dReq = 1'b1; dWe = 1'b0; dAddr = 8'h10;
    iReq = 1'b1; iAddr = 8'h00;
    k  = cyc + 1;
    da = k + 1 + W;
    ia = da + W + 2;
    for (int c = k; c <= ia; c++) busy_exp[c] = 1'b1;
    dack_exp[da] = 1'b1; dload_exp[da] = 1'b1;
    ddata_exp[da] = mem_model[8'h10]; dknown_exp[da] = mem_known[8'h10];
    iack_exp[ia] = 1'b1; idata_exp[ia] = mem_model[8'h00]; iknown_exp[ia] = mem_known[8'h00];
    while (cyc < da) @(negedge clock);
    dReq = 1'b0;
    while (cyc < ia) @(negedge clock);
    iReq = 1'b0;
    $display("txn simultaneous D load 10 ack_cyc=%0d, I fetch 00 ack_cyc=%0d", da, ia);
    @(negedge clock);
  endtask

  task automatic aborted_store(input logic [7:0] a, input logic [15:0] wd);
    int k;
    @(negedge clock);
    dReq = 1'b1; dWe = 1'b1; dAddr = a; dWdata = wd;
    k = cyc + 1;
    busy_exp[k] = 1'b1;
    while (cyc < k) @(negedge clock);
    dReq = 1'b0;
    $display("txn D store addr=%h wdata=%h aborted in WAIT cyc=%0d", a, wd, k);
    repeat (2) @(negedge clock);
  endtask

  task automatic reset_mid_fetch();
    @(negedge clock);
    iReq = 1'b1; iAddr = 8'h50;
    @(posedge clock);
    #2;
    resetN = 1'b0;
    exp_i_rdata = '0; exp_d_rdata = '0; exp_i_valid = 1'b1; exp_d_valid = 1'b1;
    #1;
    check("lit_rst_busy_now", busy, 0);
    check("lit_rst_iAck_now", iAck, 0);
    check("lit_rst_dAck_now", dAck, 0);
    @(negedge clock);
    iReq = 1'b0;
    resetN = 1'b1;
    $display("txn reset during fetch WAIT cyc=%0d", cyc);
    @(negedge clock);
  endtask

  int b0;

  initial begin
    repeat (2) @(negedge clock);
    resetN = 1'b1;
    @(negedge clock);

    access(1, 1, 8'h00, 16'h8101);
    access(1, 1, 8'h20, 16'h0000);
    access(1, 1, 8'h10, 16'h5A5A);
    reset_idle();

    b0 = busy_total;
    access(0, 0, 8'h00, 16'h0000);
    check("lit_fetch_busy_cycles", 16'(busy_total - b0), 16'd3);
`ifndef MEMORY_RESPONDER_WRITE_PROTECT_EN
    check("lit_fetch_data", iRdata, 16'h8101);
`endif
    check("lit_dRdata_after_reset", dRdata, 16'h0000);

    access(1, 1, 8'h50, 16'hBEEF);
    access(1, 0, 8'h50, 16'h0000);
    check("lit_load_beef", dRdata, 16'hBEEF);
`ifndef MEMORY_RESPONDER_WRITE_PROTECT_EN
    check("lit_iRdata_held", iRdata, 16'h8101);
`endif

    simultaneous();

    aborted_store(8'h20, 16'hDEAD);
    access(1, 0, 8'h20, 16'h0000);
`ifndef MEMORY_RESPONDER_WRITE_PROTECT_EN
    check("lit_abort_no_write", dRdata, 16'h0000);
`endif

    reset_mid_fetch();
    access(0, 0, 8'h50, 16'h0000);
    check("lit_fetch_after_reset", iRdata, 16'hBEEF);

    access(1, 1, 8'hFF, 16'h1111);
    access(1, 1, 8'h00, 16'h2222);
    access(1, 0, 8'hFF, 16'h0000);
    check("lit_load_ff", dRdata, 16'h1111);
    access(1, 0, 8'h00, 16'h0000);
`ifndef MEMORY_RESPONDER_WRITE_PROTECT_EN
    check("lit_load_00", dRdata, 16'h2222);
`endif

    access(1, 1, 8'h3F, 16'h1234);
    access(1, 0, 8'h3F, 16'h0000);
`ifdef MEMORY_RESPONDER_WRITE_PROTECT_EN
    check("lit_protected_not_written", 16'(dRdata == 16'h1234), 16'd0);
`else
    check("lit_load_3f", dRdata, 16'h1234);
`endif
    access(1, 1, 8'h40, 16'h7777);
    access(1, 0, 8'h40, 16'h0000);
    check("lit_load_40", dRdata, 16'h7777);

    repeat (2) @(negedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/memory_responder.md
Name: memory_responder

Overview:
- Memory-side responder for the multi-cycle CPU's two initiators: instruction fetch (read-only I port) and load/store (read/write D port).
- Owns a word-addressed 16-bit RAM.
- Arbitrates between the two ports and inserts a programmable number of wait states.
- Returns read data or commits a write under a req/ack handshake.
- Sits between the controller's fetch and load/store paths and the RAM array.

Parameters:
- DATA_W, 16, word width.
- ADDR_W, 8, address width; DEPTH = 2**ADDR_W words.
- WAIT_CYCLES, 1, wait states inserted before each access completes (0..15).
- PROTECT_LIMIT, 8'h40, first writable address (used only with optional feature).

Ports:
- clock  in  1  single clock; all state updates on rising edge.
- resetN  in  1  asynchronous, active-low reset.
- iReq  in  1  fetch request; held high until iAck.
- iAddr  in  ADDR_W  fetch address; stable while iReq high.
- iAck  out  1  one-cycle pulse; fetch complete.
- iRdata  out  DATA_W  fetched word; valid in the iAck cycle, held until the next iAck.
- dReq  in  1  data request; held high until dAck.
- dWe  in  1  1 = store, 0 = load; stable while dReq high.
- dAddr  in  ADDR_W  data address.
- dWdata  in  DATA_W  store data.
- dAck  out  1  one-cycle pulse; data access complete.
- dRdata  out  DATA_W  load result; valid in the dAck cycle, held until the next load dAck.
- busy  out  1  high whenever state is not IDLE.
- dErr  out  1  store rejected; exists only with the optional feature, otherwise tied 0.

Behaviour:
Reset:
- resetN low forces state IDLE, waitCnt=0, grant=none.
- iAck, dAck, dErr = 0; iRdata, dRdata = 0.
- RAM contents are not cleared by reset.

State machine IDLE -> WAIT -> ACK -> IDLE:
- IDLE: sample requests at each edge; grant a port if any req is high. Move to WAIT with waitCnt=WAIT_CYCLES, latching port, address, dWe and dWdata.
- Arbitration on simultaneous iReq and dReq: D port wins. The pending load/store belongs to the older instruction; fetch of the next one waits.
- WAIT: waitCnt decrements each edge. At waitCnt==0 the access is performed and the FSM enters ACK.
  - Read: the granted Rdata register loads RAM[addr].
  - Write: RAM[addr] <= wdata.
- ACK: the granted port's ack is high for exactly this one cycle, then IDLE.
- Latency: req seen at edge k gives ack high in the cycle after edge k+1+WAIT_CYCLES. Back-to-back throughput is one access per WAIT_CYCLES+2 cycles.

Handshake rules:
- The requester may drop req in the ACK cycle.
- If req is still high in the cycle after ACK, it is treated as a new request.
- If the granted req drops during WAIT, the access is aborted: return to IDLE, no ack, no write, Rdata unchanged.
- A losing port's req is simply left pending; its ack is never asserted spuriously.

Address and width:
- Addresses are used modulo DEPTH; no out-of-range case exists.
- Load/store at 8'hFF followed by 8'h00 behaves as two independent words.
- Read-after-write to the same address in consecutive transactions returns the new data.

Reset mid-operation:
- Asynchronous return to IDLE. An in-flight write does not commit unless its commit edge has already occurred.

Optional Feature:
- Macro MEMORY_RESPONDER_WRITE_PROTECT_EN.
- Defined:
  - Stores with address < PROTECT_LIMIT are not committed.
  - dAck still pulses, with dErr high in the same cycle.
  - Loads and fetches are unaffected.
- Undefined: all addresses are writable, and dErr is constant 0.

Decomposition:
- Shared package memory_pkg:
  - DATA_W and ADDR_W defaults.
  - FSM state enum (IDLE, WAIT, ACK).
  - Grant enum (NONE, IPORT, DPORT).
- One natural sub-module: memory_array, a single-port synchronous RAM with we, addr, wdata, rdata and no reset.
- The FSM, arbiter and wait counter stay in memory_responder.

Test Plan:
- Reset, then WAIT_CYCLES=1, iReq=1, iAddr=8'h00 with RAM[0]=16'h8101 preloaded -> iAck high exactly 3 cycles after the req edge; iRdata=16'h8101; busy high for 3 cycles.
- Store dAddr=8'h50, dWdata=16'hBEEF, then load 8'h50 -> dRdata=16'hBEEF on second dAck; iRdata unchanged.
- iReq and dReq raised on the same edge (dWe=0, dAddr=8'h10) -> dAck first; iAck follows WAIT_CYCLES+2 cycles later; no overlap of acks.
- dReq dropped during WAIT on a store to 8'h20 holding 16'h0000 -> no dAck; RAM[8'h20] reads back 16'h0000.
- resetN pulsed low during WAIT of a fetch -> iAck, dAck = 0 immediately; busy=0; the next request completes normally.
- With MEMORY_RESPONDER_WRITE_PROTECT_EN and PROTECT_LIMIT=8'h40: store 16'h1234 to 8'h3F -> dAck with dErr=1; reload of 8'h3F returns the old value. A store to 8'h40 succeeds with dErr=0.
